// File: rtl/boot_bus_handoff_pkg.sv
// Shared constants for the bootstrap bus handoff: FSM state encoding and
// default bus geometry used by the handoff top and its address decoder.
package bootstrap_pkg;

    localparam logic [1:0] COPY   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;

    localparam int         ADDRESS_BUS_WIDTH_DEFAULT = 16;
    localparam logic [7:0] IO_PAGE_DEFAULT           = 8'hFF;

    // A zero-length settle request still needs one idle edge before release.
    function automatic int settle_effective(input int cycles);
        return (cycles < 1) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/boot_address_decoder.sv
// Combinational RUN-mode decode of a CPU bus cycle into active-low RAM and IO
// selects; the RAM strobes are mutually exclusive by construction.
module boot_address_decoder
    import bootstrap_pkg::*;
#(
    parameter logic [7:0] IO_PAGE = IO_PAGE_DEFAULT
) (
    input  logic [7:0] cpu_page,
    input  logic       cpu_rw,
    input  logic       cpu_valid,
    output logic       ram_cs_n,
    output logic       ram_we_n,
    output logic       ram_oe_n,
    output logic       io_cs_n
);

    logic io_hit_s;
    logic ram_hit_s;

    // Page compare and strobe generation, zero latency from the CPU pins.
    always_comb begin
        io_hit_s  = (cpu_page == IO_PAGE);
        ram_hit_s = !io_hit_s;
        ram_cs_n  = !(cpu_valid & ram_hit_s);
        ram_oe_n  = !(cpu_valid & ram_hit_s & cpu_rw);
        ram_we_n  = !(cpu_valid & ram_hit_s & !cpu_rw);
        io_cs_n   = !(cpu_valid & io_hit_s);
    end

endmodule

// File: rtl/boot_bus_handoff.sv
// Boot bus handoff: copier owns the memory bus, an idle settle interval follows
// copy completion, then the CPU is released from reset and owns the bus.
module boot_bus_handoff
    import bootstrap_pkg::*;
#(
    parameter int         ADDRESS_BUS_WIDTH = ADDRESS_BUS_WIDTH_DEFAULT,
    parameter int         SETTLE_CYCLES     = 4,
    parameter logic [7:0] IO_PAGE           = IO_PAGE_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [ADDRESS_BUS_WIDTH-1:0] copier_address,
    input  logic                         copier_ram_we_n,
    input  logic                         copier_ram_cs_n,
    input  logic                         copier_eeprom_oe_n,
    input  logic                         copier_eeprom_cs_n,
    input  logic                         copier_done,
    input  logic [ADDRESS_BUS_WIDTH-1:0] cpu_address,
    input  logic                         cpu_rw,
    input  logic                         cpu_valid,
    output logic                         cpu_reset_n,
    output logic [ADDRESS_BUS_WIDTH-1:0] address,
    output logic                         ram_cs_n,
    output logic                         ram_we_n,
    output logic                         ram_oe_n,
    output logic                         eeprom_cs_n,
    output logic                         eeprom_oe_n,
    output logic                         io_cs_n,
    output logic                         booted
);

    localparam int SETTLE_EFF = settle_effective(SETTLE_CYCLES);
    localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] count_r;

    logic dec_ram_cs_n_s;
    logic dec_ram_we_n_s;
    logic dec_ram_oe_n_s;
    logic dec_io_cs_n_s;

    boot_address_decoder #(
        .IO_PAGE (IO_PAGE)
    ) u_decoder (
        .cpu_page  (cpu_address[ADDRESS_BUS_WIDTH-1 -: 8]),
        .cpu_rw    (cpu_rw),
        .cpu_valid (cpu_valid),
        .ram_cs_n  (dec_ram_cs_n_s),
        .ram_we_n  (dec_ram_we_n_s),
        .ram_oe_n  (dec_ram_oe_n_s),
        .io_cs_n   (dec_io_cs_n_s)
    );

    // Handoff FSM and settle counter; RUN is terminal until reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= COPY;
            count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                COPY: begin
                    if (copier_done) begin
                        state_r <= SETTLE;
                        count_r <= CNT_LOAD;
                    end
                end
                SETTLE: begin
                    if (count_r == {CNT_W{1'b0}}) begin
                        state_r <= RUN;
                    end else begin
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                RUN: begin
                    state_r <= RUN;
                end
                default: begin
                    state_r <= COPY;
                    count_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Bus owner mux; reset_n gates everything so reset takes effect without a clock.
    always_comb begin
        cpu_reset_n = 1'b0;
        booted      = 1'b0;
        address     = {ADDRESS_BUS_WIDTH{1'b0}};
        ram_cs_n    = 1'b1;
        ram_we_n    = 1'b1;
        ram_oe_n    = 1'b1;
        eeprom_cs_n = 1'b1;
        eeprom_oe_n = 1'b1;
        io_cs_n     = 1'b1;
        if (!reset_n) begin
            cpu_reset_n = 1'b0;
        end else begin
            case (state_r)
                COPY: begin
                    address     = copier_address;
                    ram_cs_n    = copier_ram_cs_n;
                    ram_we_n    = copier_ram_we_n;
                    eeprom_cs_n = copier_eeprom_cs_n;
                    eeprom_oe_n = copier_eeprom_oe_n;
                end
                RUN: begin
                    cpu_reset_n = 1'b1;
                    booted      = 1'b1;
                    address     = cpu_address;
                    ram_cs_n    = dec_ram_cs_n_s;
                    ram_we_n    = dec_ram_we_n_s;
                    ram_oe_n    = dec_ram_oe_n_s;
                    io_cs_n     = dec_io_cs_n_s;
                end
                default: begin
                    cpu_reset_n = 1'b0;
                end
            endcase
        end
    end

endmodule
